// File: rtl/router_sync_n_if.sv
// Router synchroniser bus: header/address capture, FIFO write enables and
// per-channel FIFO status. "slave" is the synchroniser side, "master" the environment side.
interface router_sync_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] valid_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  write_enb, fifo_full, valid_out, soft_reset, addr_err
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output write_enb, fifo_full, valid_out, soft_reset, addr_err
  );
endinterface

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the destination address, steers FIFO writes and
// flushes FIFOs left unread too long. Optional stats via macro ROUTER_SYNC_STAT_EN.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic               clock,
  input  logic               reset,
  router_sync_n_if.slave     bus
`ifdef ROUTER_SYNC_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [NUM_CH-1:0]  timeout_seen
`endif
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [ADDR_W:0]   NUM_CH_X = (ADDR_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0]  CNT_TC   = CNT_W'(TIMEOUT - 1);

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("router_sync_n: NUM_CH must be 2..8");
  end
  if ((1 << ADDR_W) < NUM_CH) begin : g_bad_addr_w
    $error("router_sync_n: ADDR_W too narrow for NUM_CH");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("router_sync_n: TIMEOUT must be 2..255");
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  idle_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  idle_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
  logic [NUM_CH-1:0] idle;

  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (bus.detect_add) begin
      addr_d     = bus.data_in;
      addr_err_d = ({1'b0, bus.data_in} >= NUM_CH_X);
    end
  end

  // Bad address forces fifo_full high so the upstream FSM stalls instead of dropping data.
  always_comb begin
    bus.write_enb = '0;
    bus.fifo_full = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!addr_err_q && (addr_q == ADDR_W'(k))) begin
        bus.write_enb[k] = bus.write_enb_reg;
        bus.fifo_full    = bus.full[k];
      end
    end
  end

  assign bus.valid_out = ~bus.empty;
  assign idle          = ~bus.empty & ~bus.read_enb;

  // Terminal count pulses soft_reset and restarts the count, so a stuck channel
  // is flushed every TIMEOUT cycles.
  always_comb begin
    soft_reset_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idle_cnt_d[k] = '0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (idle[k]) begin
        if (idle_cnt_q[k] == CNT_TC) begin
          soft_reset_d[k] = 1'b1;
        end else begin
          idle_cnt_d[k] = idle_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= '0;
      addr_err_q   <= 1'b0;
      soft_reset_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        idle_cnt_q[k] <= '0;
      end
    end else begin
      addr_q       <= addr_d;
      addr_err_q   <= addr_err_d;
      soft_reset_q <= soft_reset_d;
      for (int k = 0; k < NUM_CH; k++) begin
        idle_cnt_q[k] <= idle_cnt_d[k];
      end
    end
  end

  assign bus.soft_reset = soft_reset_q;
  assign bus.addr_err   = addr_err_q;

`ifdef ROUTER_SYNC_STAT_EN
  logic [NUM_CH-1:0] timeout_seen_q, timeout_seen_d;

  // A flush pulse coinciding with stat_clr must still be recorded.
  always_comb begin
    timeout_seen_d = (timeout_seen_q & ~{NUM_CH{stat_clr}}) | soft_reset_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_seen_q <= '0;
    end else begin
      timeout_seen_q <= timeout_seen_d;
    end
  end

  assign timeout_seen = timeout_seen_q;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n: vector table for address/write steering,
// per-cycle timeout sequences, and the stats option when ROUTER_SYNC_STAT_EN is defined.
module tb_router_sync_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

`ifdef ROUTER_SYNC_STAT_EN
  logic       stat_clr3;
  logic [2:0] timeout_seen3;
  router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clock(clk), .reset(rst), .bus(bus),
    .stat_clr(stat_clr3), .timeout_seen(timeout_seen3)
  );

  router_sync_n_if #(.NUM_CH(8), .ADDR_W(3)) bus8 ();
  logic       stat_clr8;
  logic [7:0] timeout_seen8;
  router_sync_n #(.NUM_CH(8), .ADDR_W(3), .TIMEOUT(4)) dut8 (
    .clock(clk), .reset(rst), .bus(bus8),
    .stat_clr(stat_clr8), .timeout_seen(timeout_seen8)
  );
`else
  router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
`endif

  typedef struct packed {
    logic [2:0] we;
    logic       ff;
    logic       err;
    logic [2:0] vo;
    logic [2:0] sr;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       det;
    logic [1:0] data;
    logic       wer;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] rd;
    exp_t       exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic sb_check(input string name);
    exp_t a;
    exp_t e;
    a = {bus.write_enb, bus.fifo_full, bus.addr_err, bus.valid_out, bus.soft_reset};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %b", name, a);
      return;
    end
    e = sb.pop_front();
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got we=%b ff=%b err=%b vo=%b sr=%b want we=%b ff=%b err=%b vo=%b sr=%b",
               name, a.we, a.ff, a.err, a.vo, a.sr, e.we, e.ff, e.err, e.vo, e.sr);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst               = 1'b1;
    bus.detect_add    = 1'b0;
    bus.data_in       = '0;
    bus.write_enb_reg = 1'b0;
    bus.read_enb      = '0;
    bus.empty         = '1;
    bus.full          = '0;
`ifdef ROUTER_SYNC_STAT_EN
    stat_clr3          = 1'b0;
    stat_clr8          = 1'b0;
    bus8.detect_add    = 1'b0;
    bus8.data_in       = '0;
    bus8.write_enb_reg = 1'b0;
    bus8.read_enb      = '0;
    bus8.empty         = '1;
    bus8.full          = '0;
`endif
    next_cycle();
    rst = 1'b0;
  endtask

  // Expected pulse for channel k: every 30 cycles after the first idle cycle
  // of its current unbroken idle stretch.
  task automatic run_idle(input string name, input int ncyc, input logic [2:0] idle_mask,
                          input int read_cyc, input logic [2:0] read_mask,
                          input int rst_cyc, input logic pre_err);
    int   start [3];
    logic err_now;
    exp_t e;
    for (int k = 0; k < 3; k++) start[k] = 1;
    err_now           = pre_err;
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.full          = '0;
    for (int i = 1; i <= ncyc; i++) begin
      bus.empty    = ~idle_mask;
      bus.read_enb = (i == read_cyc) ? read_mask : 3'b000;
      rst          = (i == rst_cyc);
      e.we  = 3'b000;
      e.err = err_now;
      e.ff  = err_now;
      e.vo  = idle_mask;
      for (int k = 0; k < 3; k++) begin
        e.sr[k] = idle_mask[k] && ((i - start[k]) >= 30) && (((i - start[k]) % 30) == 0);
        if ((i == read_cyc && read_mask[k]) || i == rst_cyc) start[k] = i + 1;
      end
      sb.push_back(e);
      @(negedge clk);
      sb_check($sformatf("%s_c%0d", name, i));
      next_cycle();
      if (i == rst_cyc) err_now = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst det data wer full    empty   rd       we      ff err vo      sr
    vecs[0]  = '{1'b1,1'b1,2'd2,1'b1,3'b001,3'b111,3'b000,'{3'b001,1'b1,1'b0,3'b000,3'b000}};
    vecs[1]  = '{1'b1,1'b1,2'd2,1'b1,3'b001,3'b111,3'b000,'{3'b001,1'b1,1'b0,3'b000,3'b000}};
    vecs[2]  = '{1'b0,1'b0,2'd0,1'b1,3'b000,3'b111,3'b000,'{3'b001,1'b0,1'b0,3'b000,3'b000}};
    vecs[3]  = '{1'b0,1'b1,2'd2,1'b1,3'b001,3'b101,3'b000,'{3'b001,1'b1,1'b0,3'b010,3'b000}};
    vecs[4]  = '{1'b0,1'b0,2'd0,1'b1,3'b100,3'b111,3'b000,'{3'b100,1'b1,1'b0,3'b000,3'b000}};
    vecs[5]  = '{1'b0,1'b0,2'd0,1'b1,3'b000,3'b111,3'b000,'{3'b100,1'b0,1'b0,3'b000,3'b000}};
    vecs[6]  = '{1'b0,1'b1,2'd3,1'b0,3'b000,3'b111,3'b000,'{3'b000,1'b0,1'b0,3'b000,3'b000}};
    vecs[7]  = '{1'b0,1'b0,2'd0,1'b1,3'b000,3'b111,3'b000,'{3'b000,1'b1,1'b1,3'b000,3'b000}};
    vecs[8]  = '{1'b0,1'b1,2'd1,1'b1,3'b010,3'b111,3'b000,'{3'b000,1'b1,1'b1,3'b000,3'b000}};
    vecs[9]  = '{1'b0,1'b0,2'd0,1'b1,3'b010,3'b111,3'b000,'{3'b010,1'b1,1'b0,3'b000,3'b000}};
    vecs[10] = '{1'b0,1'b0,2'd0,1'b1,3'b000,3'b000,3'b111,'{3'b010,1'b0,1'b0,3'b111,3'b000}};
    vecs[11] = '{1'b0,1'b1,2'd0,1'b0,3'b101,3'b111,3'b000,'{3'b000,1'b0,1'b0,3'b000,3'b000}};
    vecs[12] = '{1'b0,1'b0,2'd0,1'b1,3'b001,3'b011,3'b000,'{3'b001,1'b1,1'b0,3'b100,3'b000}};
    vecs[13] = '{1'b0,1'b0,2'd0,1'b0,3'b110,3'b111,3'b000,'{3'b000,1'b0,1'b0,3'b000,3'b000}};

    reset_dut();
    for (int i = 0; i < 14; i++) begin
      rst               = vecs[i].rst;
      bus.detect_add    = vecs[i].det;
      bus.data_in       = vecs[i].data;
      bus.write_enb_reg = vecs[i].wer;
      bus.full          = vecs[i].full;
      bus.empty         = vecs[i].empty;
      bus.read_enb      = vecs[i].rd;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      sb_check($sformatf("vec%0d", i));
      next_cycle();
    end
    rst = 1'b0;

    reset_dut();
    run_idle("to_ch0", 65, 3'b001, 0, 3'b000, 0, 1'b0);

    reset_dut();
    run_idle("to_ch1_read", 62, 3'b010, 30, 3'b010, 0, 1'b0);

    reset_dut();
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    next_cycle();
    run_idle("to_mid_rst", 40, 3'b001, 0, 3'b000, 21, 1'b1);

    reset_dut();
    run_idle("to_multi", 45, 3'b111, 10, 3'b010, 0, 1'b0);

`ifdef ROUTER_SYNC_STAT_EN
    reset_dut();
    bus8.empty = 8'h7e;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) check("stat_sr_before", {24'd0, bus8.soft_reset}, 32'h00);
      if (i == 5) check("stat_sr_pulse", {24'd0, bus8.soft_reset}, 32'h81);
      if (i == 5) check("stat_seen_before", {24'd0, timeout_seen8}, 32'h00);
      if (i == 6) check("stat_seen_set", {24'd0, timeout_seen8}, 32'h81);
      next_cycle();
    end
    bus8.empty = 8'hff;
    stat_clr8  = 1'b1;
    next_cycle();
    stat_clr8 = 1'b0;
    @(negedge clk);
    check("stat_seen_clr", {24'd0, timeout_seen8}, 32'h00);
    next_cycle();
`endif

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of output channels/FIFOs, legal 2..8.
REQ-002 SHALL have parameter ADDR_W, default 2: address field width, with 2**ADDR_W >= NUM_CH.
REQ-003 SHALL have parameter TIMEOUT, default 30: consecutive unread-valid cycles before soft reset, legal 2..255.
REQ-004 SHALL have port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: detect_add  in  1  header present; capture data_in this cycle.
REQ-007 SHALL have port: data_in  in  ADDR_W  destination channel address.
REQ-008 SHALL have port: write_enb_reg  in  1  write request from the router FSM.
REQ-009 SHALL have ports: read_enb, empty, full  in  NUM_CH each  per-channel FIFO read enable, empty and full.
REQ-010 SHALL have port: write_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-011 SHALL have port: fifo_full  out  1  full flag of the addressed channel.
REQ-012 SHALL have port: valid_out  out  NUM_CH  per-channel data-available flag.
REQ-013 SHALL have port: soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse.
REQ-014 SHALL have port: addr_err  out  1  latched address is >= NUM_CH.

Function
REQ-015 Address register SHALL load data_in only on cycles with detect_add=1; otherwise hold.
REQ-016 addr_err SHALL be registered, updated with the address register: 1 iff the captured address >= NUM_CH.
REQ-017 write_enb SHALL be combinational: bit[addr]=1 iff write_enb_reg=1 and addr_err=0; all other bits 0.
REQ-018 fifo_full SHALL equal full[addr] when addr_err=0, else 1, so the FSM stalls on bad addresses.
REQ-019 detect_add and write_enb_reg in the same cycle: write_enb and fifo_full SHALL use the previously latched address.
REQ-020 valid_out[k] SHALL equal !empty[k], combinational, zero latency.
REQ-021 Per channel k, an idle counter of width clog2(TIMEOUT) SHALL increment on each cycle with valid_out[k]=1 and read_enb[k]=0.
REQ-022 Counter SHALL clear on any cycle with valid_out[k]=0 or read_enb[k]=1; soft_reset[k] then registers 0.
REQ-023 On the TIMEOUT-th consecutive idle cycle, soft_reset[k] SHALL be 1 in the following cycle only, and the counter SHALL return to 0.
REQ-024 If channel k stays idle after a pulse, the next pulse SHALL come TIMEOUT cycles later; counter never wraps past TIMEOUT-1.
REQ-025 Channels SHALL time out independently; simultaneous pulses on multiple channels SHALL be allowed.
REQ-026 soft_reset SHALL NOT affect write_enb, fifo_full or the address register.

Reset
REQ-027 On reset=1 at a clock edge: address register=0, addr_err=0, all idle counters=0, soft_reset=0.
REQ-028 Reset mid-count SHALL discard the partial count; no pulse SHALL follow.
REQ-029 During reset, write_enb and fifo_full SHALL follow REQ-017/018 with address 0; valid_out stays combinational.

Configuration
REQ-030 With macro ROUTER_SYNC_STAT_EN defined, the block SHALL add input stat_clr (1 bit) and output timeout_seen (NUM_CH bits).
REQ-031 timeout_seen[k] SHALL set on each soft_reset[k] pulse, be sticky, clear on stat_clr=1 or reset; a set in the same cycle as stat_clr SHALL win.
REQ-032 Without ROUTER_SYNC_STAT_EN, neither port nor its logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-033 NUM_CH=3: detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100; fifo_full tracks full[2].
REQ-034 NUM_CH=3, ADDR_W=2: detect_add with data_in=3 -> addr_err=1 next cycle, write_enb=0, fifo_full=1 despite write_enb_reg=1.
REQ-035 TIMEOUT=30: empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0]=1 in cycle 31 only; 60 idle cycles give second pulse at cycle 61.
REQ-036 Idle 29 cycles, read_enb[1]=1 for one cycle, then idle -> no pulse until 30 further idle cycles.
REQ-037 reset=1 asserted after 20 idle cycles -> counters clear, no pulse at cycle 31; soft_reset, addr_err=0.
REQ-038 NUM_CH=8 with ROUTER_SYNC_STAT_EN: timeouts on channels 0 and 7 together -> both pulse, timeout_seen=8'h81; stat_clr=1 clears to 0.
